// File: rtl/byte_lane_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : byte_lane_data_mem
//  Purpose  : Byte-addressed data memory with per-lane byte enables, an
//             unaligned wrapping access window, a registered read port with a
//             valid strobe, and a sequenced clear engine that zeroes the array
//             after reset or on command while holding off requests.
//  Revision : 1.0  initial release
// ============================================================================
module byte_lane_data_mem #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic                 Req,
  input  logic                 We,
  input  logic [LANES-1:0]     ByteEn,
  input  logic [ADDR_W-1:0]    Addr,
  input  logic [8*LANES-1:0]   WrData,
  output logic                 Ready,
  output logic                 RdValid,
  output logic [8*LANES-1:0]   RdData,
  output logic                 Busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Pointer value of the final clear write; the engine leaves CLEAR on it.
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - LANES);
  localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(LANES);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clr_ptr;
  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  lane_addr [LANES];
  logic [8*LANES-1:0] rd_word;
  logic               accept;

  assign Ready  = (state == ST_IDLE) && !Clear && !Reset;
  assign Busy   = (state == ST_CLEAR);
  assign accept = Ready && Req;

  // Each lane addresses its own byte; addition wraps modulo DEPTH naturally.
  // Disabled lanes read as zero.
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_addr[i]      = Addr + ADDR_W'(i);
      assign rd_word[8*i +: 8] = ByteEn[i] ? mem[lane_addr[i]] : 8'h00;
    end
  endgenerate

  // Control FSM and registered read port; Reset outranks everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      RdValid <= 1'b0;
      RdData  <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          RdValid <= 1'b0;
          clr_ptr <= clr_ptr + PTR_STEP;
          if (clr_ptr == LAST_PTR) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (Clear) begin
            // Entering a clear drops any request this cycle and blanks RdData.
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            RdValid <= 1'b0;
            RdData  <= '0;
          end else if (accept && !We) begin
            RdValid <= 1'b1;
            RdData  <= rd_word;
          end else begin
            RdValid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          RdValid <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: one aligned zero-word per cycle while clearing, otherwise
  // the enabled lanes of an accepted write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (state == ST_CLEAR) begin
        for (int i = 0; i < LANES; i++) begin
          mem[clr_ptr + ADDR_W'(i)] <= 8'h00;
        end
      end else if (accept && We) begin
        for (int i = 0; i < LANES; i++) begin
          if (ByteEn[i]) begin
            mem[lane_addr[i]] <= WrData[8*i +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_lane_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_lane_data_mem
//  Purpose  : Scoreboarded bench for byte_lane_data_mem: a byte-array model
//             predicts read data and clear timing; a monitor compares every
//             RdValid pulse and the Ready/Busy handshake each cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_byte_lane_data_mem;

  localparam int ADDR_W = 8;
  localparam int LANES  = 2;
  localparam int DEPTH  = 256;
  localparam int WORDS  = DEPTH / LANES;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Clear = 1'b0;
  logic        Req = 1'b0;
  logic        We = 1'b0;
  logic [1:0]  ByteEn = 2'b00;
  logic [7:0]  Addr = 8'h00;
  logic [15:0] WrData = 16'h0000;
  logic        Ready;
  logic        RdValid;
  logic [15:0] RdData;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [DEPTH];
  logic [15:0] exp_q [$];
  int          busy_left = WORDS;
  bit          started = 1'b0;

  byte_lane_data_mem #(.ADDR_W(ADDR_W), .LANES(LANES)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Req(Req), .We(We),
    .ByteEn(ByteEn), .Addr(Addr), .WrData(WrData),
    .Ready(Ready), .RdValid(RdValid), .RdData(RdData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [7:0] a, input logic [1:0] be);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < LANES; i++)
      if (be[i]) r[8*i +: 8] = ref_mem[(int'(a) + i) % DEPTH];
    return r;
  endfunction

  function automatic void zero_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
  endfunction

  // Reference model: clear engine is just a countdown of remaining cycles.
  always @(posedge Clk) begin
    started = 1'b1;
    if (Reset) begin
      busy_left = WORDS;
      zero_model();
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (Clear) begin
      busy_left = WORDS;
      zero_model();
    end else if (Req) begin
      if (We) begin
        for (int i = 0; i < LANES; i++)
          if (ByteEn[i]) ref_mem[(int'(Addr) + i) % DEPTH] = WrData[8*i +: 8];
      end else begin
        exp_q.push_back(model_read(Addr, ByteEn));
      end
    end
  end

  // Monitor: handshake every cycle, read data whenever RdValid pulses.
  always @(negedge Clk) begin
    if (started) begin
      chk("ready", {15'd0, Ready}, {15'd0, (busy_left == 0) && !Clear && !Reset});
      chk("busy", {15'd0, Busy}, {15'd0, busy_left != 0});
      if (RdValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdvalid_unexpected: got RdData %h with no read pending at %0t", RdData, $time);
        end else begin
          chk("rddata", RdData, exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic rq, input logic we, input logic [1:0] be,
                       input logic [7:0] a, input logic [15:0] d, input logic clr);
    Req = rq; We = we; ByteEn = be; Addr = a; WrData = d; Clear = clr;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);
  endtask

  // Count cycles Busy stays high (bounded), then compare against expectation.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n;
    n = 0;
    Req = 1'b0; Clear = 1'b0;
    while (Busy && n < 2000) begin
      @(posedge Clk); #1;
      n++;
    end
    chk(name, 16'(n), 16'(exp_cycles));
  endtask

  initial begin
    zero_model();
    // Reset for two cycles and release.
    Reset = 1'b1;
    idle(2);
    chk("rst_rdvalid", {15'd0, RdValid}, 16'h0000);
    chk("rst_rddata", RdData, 16'h0000);
    chk("rst_busy", {15'd0, Busy}, 16'h0001);
    Reset = 1'b0;
    wait_idle("init_clear_len", WORDS);

    // Whole array reads zero.
    for (int w = 0; w < WORDS; w++) drive(1'b1, 1'b0, 2'b11, 8'(2 * w), 16'h0000, 1'b0);
    idle(2);

    // Directed accesses: full write, RAW, unaligned, wrap, partial, no-op.
    drive(1'b1, 1'b1, 2'b11, 8'h10, 16'hBEEF, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h10, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 8'h11, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 2'b11, 8'hFF, 16'h1234, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'hFF, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 8'h20, 16'hAA55, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h20, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 8'h10, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h10, 16'h0000, 1'b0);
    idle(1);
    chk("rddata_hold", RdData, 16'hBEEF);

    // Clear together with a write: write dropped, RdData blanked.
    drive(1'b1, 1'b1, 2'b11, 8'h30, 16'hCAFE, 1'b1);
    chk("clear_rddata", RdData, 16'h0000);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 2'b11, 8'($urandom_range(0, 255)), 16'h0000, 1'b0);
    wait_idle("cmd_clear_len", WORDS - 20);
    drive(1'b1, 1'b0, 2'b11, 8'h10, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 8'h30, 16'h0000, 1'b0);
    idle(2);

    // Reset 50 cycles into a clear restarts the full sweep.
    drive(1'b1, 1'b1, 2'b11, 8'h40, 16'h5A5A, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b1);
    idle(49);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    wait_idle("reset_mid_clear_len", WORDS);
    drive(1'b1, 1'b0, 2'b11, 8'h40, 16'h0000, 1'b0);
    idle(1);

    // Randomised traffic, clustered addresses for RAW and wrap coverage.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            a, 16'($urandom), $urandom_range(0, 149) == 0);
    end
    idle(WORDS + 4);
    for (int w = 0; w < 8; w++) drive(1'b1, 1'b0, 2'b11, 8'(2 * w), 16'h0000, 1'b0);
    idle(3);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_lane_data_mem.md
# byte_lane_data_mem

Parametrised, byte-addressed data memory for the processor datapath. It supersedes the fixed 8-bit × 256 store with configurable depth and word width, per-lane byte enables, a registered read port with a valid strobe, and a sequenced clear engine. The clear engine runs after reset or on command and holds off requests until the array is zeroed. It sits between the load/store unit and the datapath register file.

## Interface
- ADDR_W, 8, byte address width; DEPTH = 2**ADDR_W bytes
- LANES, 2, bytes per access word; power of two, 1..8; DEPTH must be a multiple of LANES
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Clear  in  1  synchronous request to zero the whole array (single-cycle pulse, level also accepted)
- Req  in  1  access request; accepted only when Ready=1
- We  in  1  1 = write, 0 = read
- ByteEn  in  LANES  lane i enables byte at Addr+i
- Addr  in  ADDR_W  base byte address; any alignment
- WrData  in  8*LANES  lane i = WrData[8i+7:8i]
- Ready  out  1  block accepts a request this cycle
- RdValid  out  1  one-cycle pulse, RdData valid
- RdData  out  8*LANES  registered read data, lane i = byte Addr+i
- Busy  out  1  clear engine active

## Operation
- Storage: DEPTH × 8-bit array. Lane i address = (Addr + i) mod DEPTH. Accesses wrap past DEPTH-1 to 0.
- FSM states: CLEAR, IDLE.
  - Reset → CLEAR, ClrPtr=0 (Reset has priority over everything).
  - CLEAR: each cycle, write 0 to bytes ClrPtr..ClrPtr+LANES-1, then ClrPtr += LANES. On the cycle that writes ClrPtr = DEPTH-LANES, go to IDLE. Duration is exactly DEPTH/LANES cycles.
  - IDLE with Clear=1 → CLEAR, ClrPtr=0.
- Ready = (state==IDLE) && !Clear && !Reset. Busy = (state==CLEAR).
- Requests with Req=1 while Ready=0 are ignored: no write, no RdValid. The requester must hold or reissue.
- Accepted write: each enabled lane's byte is written at that edge. Disabled lanes are untouched. RdValid stays 0.
- Accepted read: on the acceptance edge, RdData lane i is loaded with mem[Addr+i] if ByteEn[i], else 0. RdValid=1 for the following cycle only.
- ByteEn=0: the request is accepted as a no-op. A read still pulses RdValid, with RdData=0.
- Read-after-write to the same byte in consecutive accepted requests returns the new data.
- Within one access, lanes never alias, because LANES ≤ DEPTH.
- RdData holds its value until the next accepted read, Reset, or Clear entry. Reset and Clear entry zero RdData.

## Timing
- Reset values: Ready=0, Busy=1 (state CLEAR), RdValid=0, RdData=0, ClrPtr=0.
- Clear after Reset deasserts: Busy high for DEPTH/LANES cycles. Ready rises the cycle after the last clear write (defaults: 128 cycles).
- Read latency: 1 cycle (request edge → RdValid/RdData visible after that edge). Throughput is one access per cycle in IDLE.
- Write latency: 0. The data is visible to a read accepted on the next cycle.
- Reset asserted mid-CLEAR restarts the clear from ClrPtr=0. Reset asserted during a read acceptance cycle wins: RdValid=0.
- Clear asserted in the same cycle as Req: Ready=0, so the request is dropped. The clear begins the next cycle.
- Clear held high during CLEAR has no effect; the engine does not restart.

## Test plan
- Reset for 2 cycles, release → Busy=1 for exactly 128 cycles, Ready=0 throughout, then Ready=1. Every address reads 0x0000.
- Write Addr=0x10, ByteEn=2'b11, WrData=0xBEEF; next cycle read Addr=0x10 → RdValid one cycle later, RdData=0xBEEF. Read Addr=0x11, ByteEn=2'b01 → RdData=0x00BE.
- Write Addr=0xFF, ByteEn=2'b11, WrData=0x1234 → mem[0xFF]=0x34, mem[0x00]=0x12 (wrap). Read Addr=0xFF → 0x1234.
- Write Addr=0x20, ByteEn=2'b10, WrData=0xAA55 over prior 0x0000 → read Addr=0x20 returns 0xAA00. Read with ByteEn=0 → RdValid=1, RdData=0.
- Pulse Clear together with Req/We to 0x30 → write dropped, Busy=1 for 128 cycles. Reads issued during Busy get no RdValid. After Ready=1, read 0x10 returns 0.
- Assert Reset at cycle 50 of a clear, release → Busy stays high a further full 128 cycles. Earlier-written data reads 0.
